if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the single-issue MIPS-style core.
- Owns the program counter and drives the instruction ROM's chip-enable and address.
- Captures the returned instruction word and its PC into the IF/ID pipeline register for the decoder.
- The ROM is combinational: data is valid in the same cycle as the address.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard hold from the ID stage; freezes PC and IF/ID.
- jump_en  input  1  redirect request (branch taken / jump) from ID.
- jump_addr  input  32  redirect target.
- inst_i  input  32  instruction word returned by the ROM for the current pc.
- ce  output  1  ROM chip-enable; `RomEnable / `RomDisable.
- pc  output  32  fetch address to the ROM.
- id_pc  output  32  PC of the instruction held in IF/ID.
- id_inst  output  32  instruction held in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.

Behaviour:
- Reset, asynchronous, active-high, so outputs change without a clock edge:
  - ce = `RomDisable, pc = RESET_PC.
  - id_pc = `Zero, id_inst = `Zero, id_valid = 0.
- Reset release:
  - First rising edge: ce <= `RomEnable, pc stays RESET_PC. The first real fetch is RESET_PC.
  - While ce == `RomDisable, pc is held at RESET_PC and IF/ID loads a bubble.
- Per-edge priority with ce enabled: rst > jump_en > stall > sequential.
- Sequential:
  - pc <= pc + PC_STEP, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - IF/ID <= {pc, inst_i, valid = 1}.
- stall = 1, jump_en = 0: pc, id_pc, id_inst and id_valid all hold their values.
- jump_en = 1:
  - pc <= {jump_addr[31:2], 2'b00}; low two bits are forced to zero, and no misalignment fault is raised.
  - IF/ID loads a bubble: id_inst = `Zero, id_pc = `Zero, id_valid = 0. The wrong-path instruction is squashed.
  - jump_en overrides a simultaneous stall.
- Latency: an instruction fetched in cycle N appears on id_inst in cycle N+1.
- The ROM decodes only addr[11:2]. PCs at or above 32'h1000 alias in the ROM; this stage does not trap them.
- Bubble encoding: `Zero decodes as sll $0,$0,0, so it is a harmless NOP.
- Reset asserted mid-stream: all state returns to reset values immediately. The ce-then-fetch sequence repeats on release.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: MIPS branch-delay-slot semantics. On jump_en the instruction currently in IF (at pc) is not squashed; IF/ID loads {pc, inst_i, valid = 1} and pc <= target.
  - If stall and jump_en coincide, IF/ID holds (the slot instruction is already in ID), and pc still redirects.
- Undefined: squash behaviour as described under Behaviour.

Decomposition:
- Shared define file:
  - `RomEnable / `RomDisable and `Zero: existing, reuse them.
  - New: `PcStep (4), `ResetPc (32'h0), `InstNop (32'h0).
- One natural sub-module: pc_reg. It holds the PC register and ce generation, with inputs rst, stall, jump_en, jump_addr.
- The IF/ID register stays in if_stage.

Test Plan:
- Reset then release, 4 free-running cycles. Required:
  - ce = 0 and pc = 0 during reset; ce = 1 after the first edge.
  - pc sequence 0, 4, 8, 12.
  - id_inst follows ROM words 0x34011100, 0x30020020, 0x3803ff00 one cycle late, with id_valid = 1.
- stall = 1 for 2 cycles at pc = 8 -> pc stays 8 and id_pc stays 4 for both cycles; resumes at pc = 12.
- jump_en = 1 with jump_addr = 32'h0000_0023 at pc = 12. Required:
  - Next pc = 32'h20.
  - id_valid = 0 and id_inst = 0 for one cycle, then id_pc = 32'h20.
  - With DELAY_SLOT_EN, id_pc = 12 and id_valid = 1 instead of the bubble.
- jump_en and stall both asserted -> jump wins: pc = target and IF/ID bubbles (non-DELAY_SLOT_EN build).
- Force pc to 32'hFFFF_FFFC via jump -> next sequential pc = 32'h0000_0000.
- Assert rst asynchronously between edges at pc = 16 -> pc = 0, ce = 0, id_valid = 0 before the next edge.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared defines, IF/ID bundle type and helpers for the fetch stage.
// Exports: ROM enable levels, zero/NOP words, PC step/reset, if_id_t.
`ifndef RomEnable
`define RomEnable 1'b1
`endif
`ifndef RomDisable
`define RomDisable 1'b0
`endif
`ifndef Zero
`define Zero 32'h0000_0000
`endif
`ifndef PcStep
`define PcStep 4
`endif
`ifndef ResetPc
`define ResetPc 32'h0000_0000
`endif
`ifndef InstNop
`define InstNop 32'h0000_0000
`endif

package if_stage_pkg;

  localparam logic ROM_EN  = `RomEnable;
  localparam logic ROM_DIS = `RomDisable;

  localparam logic [31:0] ZERO_W   = `Zero;
  localparam logic [31:0] INST_NOP = `InstNop;
  localparam logic [31:0] PC_STEP_D  = 32'(`PcStep);
  localparam logic [31:0] RESET_PC_D = `ResetPc;

  // Word alignment for redirect targets; the low bits are dropped.
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

  // All-zero instruction is sll $0,$0,0, so a bubble is a NOP.
  localparam if_id_t IF_ID_BUBBLE = '{
    pc:    ZERO_W,
    inst:  INST_NOP,
    valid: 1'b0
  };

  function automatic if_id_t mk_if_id(
    input logic [31:0] p,
    input logic [31:0] w
  );
    if_id_t r;
    r.pc    = p;
    r.inst  = w;
    r.valid = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC register and ROM chip-enable generation for the fetch stage.
// Ports: clk, rst, stall, jump_en, jump_addr in; ce, pc out.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_D,
  parameter logic [31:0] PC_STEP  = PC_STEP_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        ce,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic        ce_d;

  always_comb begin
    ce_d = ROM_EN;
    pc_d = pc;
    if (ce == ROM_DIS) begin
      // First edge after reset only enables the ROM;
      // RESET_PC is fetched on the following cycle.
      pc_d = RESET_PC;
    end else if (jump_en) begin
      pc_d = jump_addr & PC_ALIGN_MASK;
    end else if (!stall) begin
      pc_d = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce <= ROM_DIS;
      pc <= RESET_PC;
    end else begin
      ce <= ce_d;
      pc <= pc_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: drives ROM ce/pc and captures the IF/ID register.
// Ports: clk, rst, stall, jump_en, jump_addr, inst_i in;
//        ce, pc, id_pc, id_inst, id_valid out.
// Build option: DELAY_SLOT_EN keeps the slot instruction on a jump.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic [31:0] inst_i,
  output logic        ce,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  if_id_t if_id_q;
  if_id_t if_id_d;
  if_id_t fetched;

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .ce        (ce),
    .pc        (pc)
  );

  // ROM is combinational, so inst_i belongs to the current pc.
  assign fetched = mk_if_id(pc, inst_i);

  always_comb begin
    if_id_d = if_id_q;
    if (ce == ROM_DIS) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (jump_en) begin
`ifdef DELAY_SLOT_EN
      // Slot instruction survives; on stall it is already in ID.
      if (!stall) begin
        if_id_d = fetched;
      end
`else
      // Wrong-path instruction is squashed.
      if_id_d = IF_ID_BUBBLE;
`endif
    end else if (!stall) begin
      if_id_d = fetched;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign id_pc    = if_id_q.pc;
  assign id_inst  = if_id_q.inst;
  assign id_valid = if_id_q.valid;

endmodule
